// File: rtl/btn_event_decoder.sv
// Button event decoder: turns a debounced button level into SHORT/LONG/DOUBLE pulses.
// Optional auto-repeat while held after a long press is enabled by defining BTN_EVT_REPEAT_EN.
module btn_event_decoder #(
    parameter int LONG_TICKS = 100,
    parameter int DBL_TICKS  = 30,
    parameter int RPT_TICKS  = 10,
    parameter int CNT_W      = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic BTN_I,
    output logic SHORT_O,
    output logic LONG_O,
    output logic DOUBLE_O,
    output logic REPEAT_O,
    output logic BUSY_O
);

    localparam int MAX_TICKS_C = (LONG_TICKS > DBL_TICKS)
                               ? ((LONG_TICKS > RPT_TICKS) ? LONG_TICKS : RPT_TICKS)
                               : ((DBL_TICKS > RPT_TICKS) ? DBL_TICKS : RPT_TICKS);

    // Refuse to elaborate with tick counts the timer cannot represent.
    if ((LONG_TICKS < 2) || (DBL_TICKS < 2) || (RPT_TICKS < 2) ||
        ((2 ** CNT_W) <= MAX_TICKS_C)) begin : g_param_err
        $error("btn_event_decoder: illegal tick parameters for CNT_W");
    end

    localparam logic [CNT_W-1:0] LONG_LAST_C = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DBL_LAST_C  = CNT_W'(DBL_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS1  = 3'd1,
        ST_WAIT2   = 3'd2,
        ST_WAITREL = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] timer_q;
    logic             btn_q;
    logic             armed_q;
    logic             short_q;
    logic             long_q;
    logic             double_q;
    logic             busy_q;

    logic             rise_s;
    logic             fall_s;
    logic             long_exp_s;
    logic             dbl_exp_s;
    logic [CNT_W-1:0] timer_inc_s;

    // armed_q blocks a level that was already high across reset from looking like a press.
    assign rise_s      = BTN_I & ~btn_q & armed_q;
    assign fall_s      = ~BTN_I & btn_q;
    assign long_exp_s  = CE & (timer_q == LONG_LAST_C);
    assign dbl_exp_s   = CE & (timer_q == DBL_LAST_C);
    assign timer_inc_s = timer_q + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST_C = CNT_W'(RPT_TICKS - 1);

    logic repeat_q;
    logic rpt_exp_s;

    assign rpt_exp_s = CE & (timer_q == RPT_LAST_C);
    assign REPEAT_O  = repeat_q;
`else
    logic timer_full_s;

    assign timer_full_s = &timer_q;
    assign REPEAT_O     = 1'b0;
`endif

    // Press classifier FSM with its timer, edge detector and registered event pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            timer_q  <= {CNT_W{1'b0}};
            btn_q    <= 1'b0;
            armed_q  <= ~BTN_I;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
            repeat_q <= 1'b0;
`endif
        end else begin
            btn_q    <= BTN_I;
            armed_q  <= armed_q | ~BTN_I;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
            repeat_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    // Timer is parked at zero while idle; nothing here is timed.
                    timer_q <= {CNT_W{1'b0}};
                    if (rise_s) begin
                        state_q <= ST_PRESS1;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_PRESS1: begin
                    if (fall_s) begin
                        state_q <= ST_WAIT2;
                        timer_q <= {CNT_W{1'b0}};
                    end else if (long_exp_s) begin
                        state_q <= ST_HOLD;
                        timer_q <= {CNT_W{1'b0}};
                        long_q  <= 1'b1;
                    end else if (CE) begin
                        timer_q <= timer_inc_s;
                    end else begin
                        timer_q <= timer_q;
                    end
                end
                ST_WAIT2: begin
                    if (rise_s) begin
                        state_q  <= ST_WAITREL;
                        timer_q  <= {CNT_W{1'b0}};
                        double_q <= 1'b1;
                    end else if (dbl_exp_s) begin
                        state_q  <= ST_IDLE;
                        timer_q  <= {CNT_W{1'b0}};
                        busy_q   <= 1'b0;
                        short_q  <= 1'b1;
                    end else if (CE) begin
                        timer_q  <= timer_inc_s;
                    end else begin
                        timer_q  <= timer_q;
                    end
                end
                ST_WAITREL: begin
                    timer_q <= {CNT_W{1'b0}};
                    if (!BTN_I) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_WAITREL;
                    end
                end
                ST_HOLD: begin
                    if (!BTN_I) begin
                        state_q <= ST_IDLE;
                        timer_q <= {CNT_W{1'b0}};
                        busy_q  <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
                    end else if (rpt_exp_s) begin
                        timer_q  <= {CNT_W{1'b0}};
                        repeat_q <= 1'b1;
                    end else if (CE) begin
                        timer_q  <= timer_inc_s;
`else
                    end else if (CE && !timer_full_s) begin
                        timer_q <= timer_inc_s;
`endif
                    end else begin
                        timer_q <= timer_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= {CNT_W{1'b0}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign SHORT_O  = short_q;
    assign LONG_O   = long_q;
    assign DOUBLE_O = double_q;
    assign BUSY_O   = busy_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with LONG=4, DBL=3, RPT=2; outputs are checked every
// cycle as {SHORT, LONG, DOUBLE, REPEAT, BUSY}.
module tb_btn_event_decoder;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic CE = 1'b1;
    logic BTN_I = 1'b0;
    logic SHORT_O, LONG_O, DOUBLE_O, REPEAT_O, BUSY_O;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BTN_EVT_REPEAT_EN
    localparam logic REP_ON = 1'b1;
`else
    localparam logic REP_ON = 1'b0;
`endif

    localparam logic [4:0] V_IDLE  = 5'b00000;
    localparam logic [4:0] V_BUSY  = 5'b00001;
    localparam logic [4:0] V_SHORT = 5'b10000;
    localparam logic [4:0] V_LONG  = 5'b01001;
    localparam logic [4:0] V_DBL   = 5'b00101;
    localparam logic [4:0] V_REP   = {3'b000, REP_ON, 1'b1};

    btn_event_decoder #(
        .LONG_TICKS (4),
        .DBL_TICKS  (3),
        .RPT_TICKS  (2),
        .CNT_W      (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CE       (CE),
        .BTN_I    (BTN_I),
        .SHORT_O  (SHORT_O),
        .LONG_O   (LONG_O),
        .DOUBLE_O (DOUBLE_O),
        .REPEAT_O (REPEAT_O),
        .BUSY_O   (BUSY_O)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic rst, input logic ce, input logic btn,
                        input logic [4:0] exp_v, input string tag);
        logic [4:0] obs;
        RST   = rst;
        CE    = ce;
        BTN_I = btn;
        @(posedge CLK);
        #1;
        obs = {SHORT_O, LONG_O, DOUBLE_O, REPEAT_O, BUSY_O};
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (S L D R B)", tag, obs, exp_v);
        end
    endtask

    initial begin
        // Reset with button held: the held level must not count as a press.
        step(1'b1, 1'b1, 1'b1, V_IDLE, "rst_hold0");
        step(1'b1, 1'b1, 1'b1, V_IDLE, "rst_hold1");
        step(1'b1, 1'b1, 1'b1, V_IDLE, "rst_hold2");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, V_IDLE, "post_rst_high");
        step(1'b0, 1'b1, 1'b0, V_IDLE, "post_rst_low");

        // Short press: 2 cycles high, SHORT 3 ticks after release plus one register cycle.
        step(1'b0, 1'b1, 1'b1, V_BUSY, "short_rise");
        step(1'b0, 1'b1, 1'b1, V_BUSY, "short_held");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "short_fall");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "short_w1");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "short_w2");
        step(1'b0, 1'b1, 1'b0, V_SHORT, "short_pulse");
        step(1'b0, 1'b1, 1'b0, V_IDLE, "short_after");

        // Long press held through the repeat ticks; REPEAT only when the macro is on.
        step(1'b0, 1'b1, 1'b1, V_BUSY, "long_rise");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, V_BUSY, "long_count");
        step(1'b0, 1'b1, 1'b1, V_LONG, "long_pulse");
        step(1'b0, 1'b1, 1'b1, V_BUSY, "hold_t5");
        step(1'b0, 1'b1, 1'b1, V_REP, "hold_rep6");
        step(1'b0, 1'b1, 1'b1, V_BUSY, "hold_t7");
        step(1'b0, 1'b1, 1'b1, V_REP, "hold_rep8");
        step(1'b0, 1'b1, 1'b1, V_BUSY, "hold_t9");
        step(1'b0, 1'b1, 1'b1, V_REP, "hold_rep10");
        step(1'b0, 1'b1, 1'b0, V_IDLE, "long_release");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, V_IDLE, "long_no_short");

        // Double press: second rise one cycle after release.
        step(1'b0, 1'b1, 1'b1, V_BUSY, "dbl_rise1");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "dbl_fall1");
        step(1'b0, 1'b1, 1'b1, V_DBL, "dbl_pulse");
        step(1'b0, 1'b1, 1'b1, V_BUSY, "dbl_waitrel");
        step(1'b0, 1'b1, 1'b0, V_IDLE, "dbl_release");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, V_IDLE, "dbl_no_short");

        // Double press with the second rise exactly on the double-window expiry.
        step(1'b0, 1'b1, 1'b1, V_BUSY, "dblx_rise1");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "dblx_fall1");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "dblx_w1");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "dblx_w2");
        step(1'b0, 1'b1, 1'b1, V_DBL, "dblx_pulse");
        step(1'b0, 1'b1, 1'b0, V_IDLE, "dblx_release");
        step(1'b0, 1'b1, 1'b0, V_IDLE, "dblx_after");

        // Release on the long expiry cycle: no LONG, falls into the double window instead.
        step(1'b0, 1'b1, 1'b1, V_BUSY, "lx_rise");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, V_BUSY, "lx_count");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "lx_fall_no_long");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "lx_w1");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "lx_w2");
        step(1'b0, 1'b1, 1'b0, V_SHORT, "lx_short");
        step(1'b0, 1'b1, 1'b0, V_IDLE, "lx_after");

        // CE every 4th cycle: the double window stretches to 12 cycles.
        step(1'b0, 1'b0, 1'b1, V_BUSY, "ce4_rise");
        step(1'b0, 1'b0, 1'b0, V_BUSY, "ce4_fall");
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, V_BUSY, "ce4_idle_tick");
            step(1'b0, 1'b1, 1'b0, (g == 2) ? V_SHORT : V_BUSY, "ce4_tick");
        end
        step(1'b0, 1'b0, 1'b0, V_IDLE, "ce4_after");

        // Reset in the middle of HOLD: back to idle, still-held level is ignored.
        step(1'b0, 1'b1, 1'b1, V_BUSY, "rh_rise");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, V_BUSY, "rh_count");
        step(1'b0, 1'b1, 1'b1, V_LONG, "rh_long");
        step(1'b0, 1'b1, 1'b1, V_BUSY, "rh_hold");
        step(1'b1, 1'b1, 1'b1, V_IDLE, "rh_reset");
        step(1'b0, 1'b1, 1'b1, V_IDLE, "rh_post1");
        step(1'b0, 1'b1, 1'b1, V_IDLE, "rh_post2");
        step(1'b0, 1'b1, 1'b0, V_IDLE, "rh_low");

        // Low during reset then high right after: that is a real 0->1 press.
        step(1'b1, 1'b1, 1'b0, V_IDLE, "rl_reset");
        step(1'b0, 1'b1, 1'b1, V_BUSY, "rl_rise");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "rl_fall");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "rl_w1");
        step(1'b0, 1'b1, 1'b0, V_BUSY, "rl_w2");
        step(1'b0, 1'b1, 1'b0, V_SHORT, "rl_short");
        step(1'b0, 1'b1, 1'b0, V_IDLE, "rl_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
